// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle between two pipeline stages: upstream beat, downstream beat, flush and occupancy.
// The register block takes the slave modport; whoever drives and consumes beats takes master.
interface pipe_skid_reg_if #(
  parameter int PAYLOAD_W = 64
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_data;
  logic [1:0]           count;

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush and an optional
// two-entry skid buffer that registers in_ready to cut the combinational ready path.
module pipe_skid_reg #(
  parameter int                   PAYLOAD_W = 64,
  parameter bit                   SKID      = 1'b1,
  parameter logic [PAYLOAD_W-1:0] RST_VAL   = {PAYLOAD_W{1'b0}}
) (
  input  logic          clk,
  input  logic          rstn,
  pipe_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [PAYLOAD_W-1:0] main_reg;
  logic [PAYLOAD_W-1:0] main_next;
  logic [PAYLOAD_W-1:0] skid_reg;
  logic [PAYLOAD_W-1:0] skid_next;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic pop;

  assign out_valid = (state_reg != EMPTY);
  assign accept    = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= EMPTY;
      main_reg  <= RST_VAL;
      skid_reg  <= RST_VAL;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  // Flush wins over everything; payload registers keep their contents since out_data is
  // don't-care while out_valid is low.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (bus.flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            main_next  = bus.in_data;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_next = bus.in_data;
          end else if (accept && SKID) begin
            state_next = FULL;
            skid_next  = bus.in_data;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_next = ONE;
            main_next  = skid_reg;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  generate
    if (SKID) begin : g_skid_ready
      logic in_ready_reg;

      // Ready is a pure flop output so the upstream stage never sees out_ready combinationally.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          in_ready_reg <= 1'b1;
        end else begin
          in_ready_reg <= (state_next != FULL);
        end
      end

      assign in_ready = in_ready_reg;
    end else begin : g_comb_ready
      assign in_ready = ~out_valid | bus.out_ready;
    end
  endgenerate

  always_comb begin
    bus.count = 2'd0;
    unique case (state_reg)
      ONE:     bus.count = 2'd1;
      FULL:    bus.count = 2'd2;
      default: bus.count = 2'd0;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_reg;

  a_hold_stable: assert property (@(posedge clk) disable iff (!rstn)
    (out_valid && !bus.out_ready && !bus.flush) |=> (out_valid && $stable(main_reg)));

  a_no_full_without_skid: assert property (@(posedge clk) disable iff (!rstn)
    (!SKID) |-> (state_reg != FULL));

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized checks of pipe_skid_reg with and without the skid buffer.
module tb_pipe_skid_reg;

  localparam logic [63:0] RV1 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] RV0 = 64'h0;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.PAYLOAD_W(64)) b1 ();
  pipe_skid_reg_if #(.PAYLOAD_W(64)) b0 ();

  pipe_skid_reg #(.PAYLOAD_W(64), .SKID(1'b1), .RST_VAL(RV1)) dut1 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b1)
  );

  pipe_skid_reg #(.PAYLOAD_W(64), .SKID(1'b0), .RST_VAL(RV0)) dut0 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp,
                     input bit quiet = 1'b0);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else if (!quiet) begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] q1[$];
  logic [63:0] q0[$];

  initial begin
    logic        iv1, or1, fl1, iv0, or0, fl0;
    logic [63:0] d1, d0;
    logic        er1, er0;

    b1.flush = 1'b0; b1.out_ready = 1'b0; b1.in_valid = 1'b1; b1.in_data = 64'hAA;
    b0.flush = 1'b0; b0.out_ready = 1'b0; b0.in_valid = 1'b1; b0.in_data = 64'hAA;

    // Reset held across clock edges while upstream offers a beat
    step(); step();
    chk("rst1_out_valid", 64'(b1.out_valid), 64'd0);
    chk("rst1_in_ready",  64'(b1.in_ready),  64'd1);
    chk("rst1_count",     64'(b1.count),     64'd0);
    chk("rst1_out_data",  b1.out_data,       RV1);
    chk("rst0_out_valid", 64'(b0.out_valid), 64'd0);
    chk("rst0_out_data",  b0.out_data,       RV0);
    b1.in_valid = 1'b0; b0.in_valid = 1'b0;
    rstn = 1'b1;

    // Back-to-back streaming, skid build
    b1.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      b1.in_valid = 1'b1;
      b1.in_data  = 64'(i);
      step();
      chk($sformatf("s1_data%0d", i), b1.out_data, 64'(i));
      chk($sformatf("s1_valid%0d", i), 64'(b1.out_valid), 64'd1);
      chk($sformatf("s1_count%0d", i), 64'(b1.count), 64'd1);
      chk($sformatf("s1_ready%0d", i), 64'(b1.in_ready), 64'd1);
    end
    b1.in_valid = 1'b0;
    step();
    chk("s1_drain_valid", 64'(b1.out_valid), 64'd0);
    chk("s1_drain_count", 64'(b1.count), 64'd0);

    // Backpressure fills the skid entry
    b1.out_ready = 1'b0;
    b1.in_valid = 1'b1; b1.in_data = 64'h11;
    step();
    chk("bp_one_ready", 64'(b1.in_ready), 64'd1);
    b1.in_data = 64'h22;
    step();
    b1.in_valid = 1'b0;
    chk("bp_full_count", 64'(b1.count), 64'd2);
    chk("bp_full_ready", 64'(b1.in_ready), 64'd0);
    chk("bp_full_data",  b1.out_data, 64'h11);
    step();
    chk("bp_hold_data",  b1.out_data, 64'h11);
    chk("bp_hold_count", 64'(b1.count), 64'd2);
    b1.out_ready = 1'b1;
    step();
    chk("bp_pop1_data",  b1.out_data, 64'h22);
    chk("bp_pop1_ready", 64'(b1.in_ready), 64'd1);
    chk("bp_pop1_count", 64'(b1.count), 64'd1);
    step();
    chk("bp_pop2_valid", 64'(b1.out_valid), 64'd0);

    // Flush from FULL with a beat offered, then flush racing an accept from EMPTY
    b1.out_ready = 1'b0;
    b1.in_valid = 1'b1; b1.in_data = 64'h01; step();
    b1.in_data = 64'h02; step();
    chk("fl_pre_count", 64'(b1.count), 64'd2);
    b1.flush = 1'b1; b1.in_data = 64'h33;
    step();
    chk("fl_valid", 64'(b1.out_valid), 64'd0);
    chk("fl_count", 64'(b1.count), 64'd0);
    chk("fl_ready", 64'(b1.in_ready), 64'd1);
    step();
    chk("fl_empty_accept_valid", 64'(b1.out_valid), 64'd0);
    b1.flush = 1'b0; b1.out_ready = 1'b1; b1.in_data = 64'h44;
    step();
    b1.in_valid = 1'b0;
    chk("fl_next_valid", 64'(b1.out_valid), 64'd1);
    chk("fl_next_data",  b1.out_data, 64'h44);
    step();
    chk("fl_next_drain", 64'(b1.out_valid), 64'd0);

    // Single register: combinational ready, pop and accept on the same edge
    b0.out_ready = 1'b0; b0.in_valid = 1'b1; b0.in_data = 64'h55;
    step();
    b0.in_valid = 1'b0;
    #1;
    chk("s0_held_data",  b0.out_data, 64'h55);
    chk("s0_stall_ready", 64'(b0.in_ready), 64'd0);
    b0.out_ready = 1'b1; b0.in_valid = 1'b1; b0.in_data = 64'h66;
    #1;
    chk("s0_comb_ready", 64'(b0.in_ready), 64'd1);
    step();
    chk("s0_swap_data",  b0.out_data, 64'h66);
    chk("s0_swap_count", 64'(b0.count), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      b0.in_data = 64'(16 + i);
      step();
      chk($sformatf("s0_stream%0d", i), b0.out_data, 64'(16 + i));
    end
    b0.in_valid = 1'b0;
    step();
    chk("s0_drain_valid", 64'(b0.out_valid), 64'd0);

    // Asynchronous reset while FULL, checked before any clock edge
    b1.out_ready = 1'b0; b1.in_valid = 1'b1;
    b1.in_data = 64'hA1; step();
    b1.in_data = 64'hA2; step();
    b1.in_valid = 1'b0;
    chk("ar_pre_count", 64'(b1.count), 64'd2);
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid", 64'(b1.out_valid), 64'd0);
    chk("ar_count", 64'(b1.count), 64'd0);
    chk("ar_ready", 64'(b1.in_ready), 64'd1);
    chk("ar_data",  b1.out_data, RV1);
    step();
    rstn = 1'b1;

    // Random traffic against reference queues for both variants
    for (int c = 0; c < 10000; c++) begin
      iv1 = ($urandom_range(3) != 0); or1 = ($urandom_range(2) != 0); fl1 = ($urandom_range(39) == 0);
      iv0 = ($urandom_range(3) != 0); or0 = ($urandom_range(2) != 0); fl0 = ($urandom_range(39) == 0);
      d1 = {$urandom, $urandom}; d0 = {$urandom, $urandom};
      b1.in_valid = iv1; b1.out_ready = or1; b1.flush = fl1; b1.in_data = d1;
      b0.in_valid = iv0; b0.out_ready = or0; b0.flush = fl0; b0.in_data = d0;
      #1;
      er1 = (q1.size() < 2);
      er0 = (q0.size() == 0) || or0;
      chk("r1_ready", 64'(b1.in_ready), 64'(er1), 1'b1);
      chk("r1_valid", 64'(b1.out_valid), 64'(q1.size() > 0), 1'b1);
      chk("r1_count", 64'(b1.count), 64'(q1.size()), 1'b1);
      if (q1.size() > 0) chk("r1_data", b1.out_data, q1[0], 1'b1);
      chk("r0_ready", 64'(b0.in_ready), 64'(er0), 1'b1);
      chk("r0_valid", 64'(b0.out_valid), 64'(q0.size() > 0), 1'b1);
      chk("r0_count", 64'(b0.count), 64'(q0.size()), 1'b1);
      if (q0.size() > 0) chk("r0_data", b0.out_data, q0[0], 1'b1);
      if (or1 && q1.size() > 0) void'(q1.pop_front());
      if (iv1 && er1) q1.push_back(d1);
      if (fl1) q1.delete();
      if (or0 && q0.size() > 0) void'(q0.pop_front());
      if (iv0 && er0) q0.push_back(d0);
      if (fl0) q0.delete();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, synchronous flush and an optional skid buffer. It carries one payload beat per cycle between two pipeline stages, such as execute → load/store or load/store → writeback. It replaces free-running stage registers so that a downstream stall holds data instead of overwriting it. With SKID=1 it breaks the combinational ready path between stages.

## Interface
- PAYLOAD_W, default 64: payload width in bits (PC, instruction, ALU result, control bits packed by the instantiating stage).
- SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- RST_VAL, default {PAYLOAD_W{1'b0}}: reset value of the main and skid payload registers.
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous kill of all held beats and of any beat accepted this cycle.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  PAYLOAD_W  upstream payload.
- out_valid  output  1  main register holds a valid beat.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  PAYLOAD_W  main register payload.
- count  output  2  number of held beats (0..2; never exceeds 1 when SKID=0).

## Operation
- A beat is accepted when in_valid & in_ready. A beat is popped when out_valid & out_ready.
- States: EMPTY (count 0), ONE (main valid), FULL (main + skid valid; reachable only when SKID=1).
- out_valid = (state != EMPTY). out_data = main register.
- in_ready:
  - SKID=1: in_ready = (state != FULL), taken from a register only.
  - SKID=0: in_ready = ~out_valid | out_ready.
- Transitions when flush=0:
  - EMPTY: accept → ONE, main ← in_data.
  - ONE, accept & pop → ONE, main ← in_data.
  - ONE, accept & ~pop:
    - SKID=1 → FULL, skid ← in_data.
    - SKID=0 cannot occur, because in_ready=0.
  - ONE, ~accept & pop → EMPTY.
  - ONE, neither → hold.
  - FULL, pop → ONE, main ← skid. No accept is possible in FULL.
  - FULL, no pop → hold.
- flush=1 has highest priority:
  - Next state is EMPTY and count is 0.
  - A beat popped in the same cycle counts as delivered.
  - A beat accepted in the same cycle is discarded.
  - Payload registers are not cleared; out_data is don't-care while out_valid=0.
- Stability: while out_valid & ~out_ready and no flush, out_valid and out_data must not change.
- Ordering: beats leave strictly in acceptance order. No beat is duplicated or dropped except by flush or reset.

## Timing
- Reset (asynchronous, effective without a clock edge):
  - state EMPTY, out_valid 0, count 0.
  - in_ready 1.
  - main and skid payload registers = RST_VAL, so out_data = RST_VAL.
- Reset deassertion is synchronised by the system. The first accept is possible on the first rising edge after rstn=1.
- Latency: an accept at edge N into EMPTY gives out_valid=1 with that data after edge N.
- Throughput: 1 beat/cycle sustained when out_ready=1, for both SKID values, with no bubbles.
- SKID=1:
  - in_ready falls the cycle after the accept that fills the skid register.
  - in_ready rises the cycle after the pop from FULL.
  - There is no combinational path from out_ready or in_valid to in_ready.
- SKID=0: combinational path from out_ready to in_ready. A pop and an accept on the same edge are allowed.
- flush is sampled on the rising edge. Outputs reflect EMPTY after that edge.

## Test plan
- Reset: hold rstn=0 while driving in_valid=1 and in_data=0xAA → out_valid=0, in_ready=1, count=0, out_data=RST_VAL. Assert rstn=0 mid-FULL → same values without any clock edge.
- Streaming, SKID=1, PAYLOAD_W=64, out_ready=1: send beats 1..8 back-to-back → out_data sequence 1..8, each one cycle after its accept; out_valid continuous; count stays 1; in_ready stays 1.
- Backpressure, SKID=1, out_ready=0: accept A=0x11 then B=0x22 → count=2, in_ready=0, out_data=0x11 held. Raise out_ready → pops 0x11 then 0x22 on consecutive cycles; in_ready=1 one cycle after the first pop.
- Flush, FULL, in_valid=1, in_data=0x33 → after the edge: out_valid=0, count=0, 0x33 never appears. The next accepted beat 0x44 appears normally.
- SKID=0, ONE holding 0x55, out_ready=0 → in_ready=0. Set out_ready=1 with in_valid=1, in_data=0x66 in the same cycle → in_ready=1 in that cycle; after the edge out_data=0x66 and count=1.
- Random stall/valid/flush traffic, 10k cycles against a scoreboard queue → order is preserved; no loss or duplication except beats killed by flush; count matches the reference queue depth.
